add_pipe: RTL

- Parametrised, pipelined adder/subtractor; successor to the combinational 32-bit adder.
- Splits the operand into STAGES equal chunks. Each pipeline stage adds one chunk and passes its carry to the next stage.
- Adds a carry-in, a subtract mode, ALU-style flags and valid/ready handshakes on input and output.
- Use it where a WIDTH-bit add would limit clock frequency; throughput is one result per cycle.

---
 rtl/add_pipe_if.sv | 28 ++
 rtl/add_pipe.sv | 91 +++++++++
 2 files changed

// File: rtl/add_pipe_if.sv
// Handshake and data bundle for add_pipe: operation request in, flagged result out.
interface add_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;
  logic             out_neg;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_q, out_carry, out_ovf, out_zero, out_neg
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_q, out_carry, out_ovf, out_zero, out_neg
  );
endinterface

// File: rtl/add_pipe.sv
// Pipelined adder/subtractor: STAGES chunks of WIDTH/STAGES bits, one chunk per stage,
// carry rippling stage to stage; ALU flags registered alongside the final result.
module add_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic       clk,
  input  logic       rst,
  add_pipe_if.slave  bus
);
  localparam int unsigned C = WIDTH / STAGES;

  logic              adv;
  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] cy_r;
  logic [STAGES-1:0] cy_n;
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  q_r [STAGES];
  logic [WIDTH-1:0]  a_n [STAGES];
  logic [WIDTH-1:0]  b_n [STAGES];
  logic [WIDTH-1:0]  q_n [STAGES];
  logic [C:0]        sum;
  logic              ovf_n, zero_n, neg_n;
  logic              ovf_r, zero_r, neg_r;

  // A single advance enable moves the whole pipe; a stalled output freezes every stage.
  assign adv          = !vld_r[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    sum = '0;
    // Stage 0 takes the raw request; B is inverted and +1 injected for subtract.
    a_n[0] = bus.in_a;
    b_n[0] = bus.in_b ^ {WIDTH{bus.in_sub}};
    q_n[0] = '0;
    sum    = {1'b0, a_n[0][C-1:0]} + {1'b0, b_n[0][C-1:0]}
           + {{C{1'b0}}, (bus.in_sub | bus.in_cin)};
    q_n[0][C-1:0] = sum[C-1:0];
    cy_n[0]       = sum[C];
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_n[k] = a_r[k-1];
      b_n[k] = b_r[k-1];
      q_n[k] = q_r[k-1];
      sum    = {1'b0, a_n[k][k*C +: C]} + {1'b0, b_n[k][k*C +: C]}
             + {{C{1'b0}}, cy_r[k-1]};
      q_n[k][k*C +: C] = sum[C-1:0];
      cy_n[k]          = sum[C];
    end
    neg_n  = q_n[STAGES-1][WIDTH-1];
    zero_n = (q_n[STAGES-1] == '0);
    ovf_n  = (a_n[STAGES-1][WIDTH-1] == b_n[STAGES-1][WIDTH-1])
          && (q_n[STAGES-1][WIDTH-1] != a_n[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r  <= '0;
      cy_r   <= '0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
      neg_r  <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        q_r[k] <= '0;
      end
    end else if (adv) begin
      vld_r[0] <= bus.in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld_r[k] <= vld_r[k-1];
      end
      cy_r   <= cy_n;
      ovf_r  <= ovf_n;
      zero_r <= zero_n;
      neg_r  <= neg_n;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_r[k] <= a_n[k];
        b_r[k] <= b_n[k];
        q_r[k] <= q_n[k];
      end
    end
  end

  assign bus.out_valid = vld_r[STAGES-1];
  assign bus.out_q     = q_r[STAGES-1];
  assign bus.out_carry = cy_r[STAGES-1];
  assign bus.out_ovf   = ovf_r;
  assign bus.out_zero  = zero_r;
  assign bus.out_neg   = neg_r;
endmodule
